// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer: state encodings
// and the default datapath sizes matching the register data bus.
package div_seq_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. It stalls the pipeline
// while iterating and pulses result_valid for the HI/LO write.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = DIV_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic                  annul,
  output logic                  stall_req,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  counter_q, counter_d;
  logic [DATA_WIDTH:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH-1:0] mag1, mag2;
  logic [DATA_WIDTH+1:0] trial;
  logic [DATA_WIDTH:0]   step_acc;
  logic [DATA_WIDTH-1:0] step_dvd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= DIV_IDLE;
      counter_q   <= '0;
      acc_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      acc_q       <= acc_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    acc_d       = acc_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    mag1 = (signed_div && operand1[DATA_WIDTH-1]) ? -operand1 : operand1;
    mag2 = (signed_div && operand2[DATA_WIDTH-1]) ? -operand2 : operand2;

    // One restoring step: the sign bit of the widened difference decides keep/restore.
    trial    = {acc_q, dvd_q[DATA_WIDTH-1]} - {2'b00, dvs_q};
    step_acc = trial[DATA_WIDTH+1] ? {acc_q[DATA_WIDTH-1:0], dvd_q[DATA_WIDTH-1]}
                                   : trial[DATA_WIDTH:0];
    step_dvd = {dvd_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH+1]};

    case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          neg_quot_d = signed_div && (operand1[DATA_WIDTH-1] != operand2[DATA_WIDTH-1]);
          neg_rem_d  = signed_div && operand1[DATA_WIDTH-1];
          counter_d  = '0;
          acc_d      = '0;
          dvs_d      = mag2;
          // A zero divisor parks the raw dividend here so ZERO can return it.
          if (operand2 == '0) begin
            dvd_d   = operand1;
            state_d = DIV_ZERO;
          end else begin
            dvd_d   = mag1;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_ZERO: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          quotient_d  = '0;
          remainder_d = dvd_q;
          dbz_d       = 1'b1;
          state_d     = DIV_DONE;
        end
      end
      DIV_RUN: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          acc_d     = step_acc;
          dvd_d     = step_dvd;
          counter_d = counter_q + CNT_WIDTH'(1);
          if (counter_q == LAST_CNT) begin
            quotient_d  = neg_quot_q ? -step_dvd : step_dvd;
            remainder_d = neg_rem_q ? -step_acc[DATA_WIDTH-1:0] : step_acc[DATA_WIDTH-1:0];
            dbz_d       = 1'b0;
            state_d     = DIV_DONE;
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign stall_req    = reset && ((state_q == DIV_IDLE && start && !annul) ||
                                  state_q == DIV_ZERO || state_q == DIV_RUN);
  assign result_valid = (state_q == DIV_DONE);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a vector table of divisions plus hand-written
// sequences for annul, asynchronous reset and back-to-back operation.
module tb_div_seq;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          signed_div = 1'b0;
  logic [DW-1:0] operand1 = '0;
  logic [DW-1:0] operand2 = '0;
  logic          annul = 1'b0;
  logic          stall_req;
  logic          result_valid;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic          sgn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    int            lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  div_seq dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .signed_div   (signed_div),
    .operand1     (operand1),
    .operand2     (operand2),
    .annul        (annul),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one division from IDLE and waits (bounded) for result_valid.
  task automatic applyStimulus(input logic sgn, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, output int lat);
    logic stall_ok;
    @(negedge clock);
    signed_div = sgn;
    operand1   = a;
    operand2   = b;
    start      = 1'b1;
    #1;
    checkOutput("stall_req cycle 0", stall_req, 1'b1);
    lat      = -1;
    stall_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (result_valid) begin
        lat = n;
        break;
      end
      if (!stall_req) stall_ok = 1'b0;
    end
    start = 1'b0;
    checkOutput("stall_req held while busy", stall_ok, 1'b1);
  endtask

  initial begin
    int lat;
    int lat2;
    logic seen;
    logic [DW-1:0] prev_q;
    logic [DW-1:0] prev_r;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
    vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'h0,          1'b0, 33};
    vecs[3]  = '{1'b0, 32'h1234,      32'h0,          32'h0,          32'h1234,       1'b1, 2};
    vecs[4]  = '{1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'h0,          1'b0, 33};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'h10,         32'h0FFFFFFF,   32'hF,          1'b0, 33};
    vecs[8]  = '{1'b0, 32'd5,         32'd9,          32'd0,          32'd5,          1'b0, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFFFB,  32'h0,          32'h0,          32'hFFFFFFFB,   1'b1, 2};
    vecs[10] = '{1'b1, 32'h80000000,  32'd2,          32'hC0000000,   32'h0,          1'b0, 33};
    vecs[11] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,   32'h0,          32'h80000000,   1'b0, 33};
    vecs[12] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,          32'h0,          1'b0, 33};
    vecs[13] = '{1'b0, 32'd123456789, 32'd1000,       32'd123456,     32'd789,        1'b0, 33};

    // Reset state, including stall_req suppressed while reset is low.
    repeat (3) @(negedge clock);
    start = 1'b1;
    #1;
    checkOutput("reset stall_req", stall_req, 1'b0);
    checkOutput("reset result_valid", result_valid, 1'b0);
    checkOutput("reset quotient", quotient, '0);
    checkOutput("reset remainder", remainder, '0);
    checkOutput("reset div_by_zero", div_by_zero, 1'b0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
      checkOutput($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
      checkOutput($sformatf("vec%0d div_by_zero", i), div_by_zero, vecs[i].dbz);
      checkOutput($sformatf("vec%0d stall_req in DONE", i), stall_req, 1'b0);
      @(negedge clock);
      checkOutput($sformatf("vec%0d result_valid pulse", i), result_valid, 1'b0);
    end
    prev_q = vecs[NVEC-1].q;
    prev_r = vecs[NVEC-1].r;

    // Annul during RUN cycle 10: no result, outputs untouched.
    @(negedge clock);
    signed_div = 1'b0;
    operand1   = 32'd1000;
    operand2   = 32'd3;
    start      = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("annul stall_req in RUN", stall_req, 1'b1);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clock);
    annul = 1'b0;
    #1;
    checkOutput("annul stall_req after", stall_req, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (result_valid) seen = 1'b1;
    end
    checkOutput("annul no result_valid", seen, 1'b0);
    checkOutput("annul quotient held", quotient, prev_q);
    checkOutput("annul remainder held", remainder, prev_r);
    checkOutput("annul div_by_zero held", div_by_zero, 1'b0);

    applyStimulus(1'b0, 32'd9, 32'd3, lat);
    checkOutput("9/3 latency", lat, 33);
    checkOutput("9/3 quotient", quotient, 32'd3);
    checkOutput("9/3 remainder", remainder, 32'd0);

    // Asynchronous reset at RUN cycle 20.
    @(negedge clock);
    operand1 = 32'd1000;
    operand2 = 32'd3;
    start    = 1'b1;
    repeat (20) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset quotient", quotient, '0);
    checkOutput("async reset remainder", remainder, '0);
    checkOutput("async reset div_by_zero", div_by_zero, 1'b0);
    checkOutput("async reset stall_req", stall_req, 1'b0);
    checkOutput("async reset result_valid", result_valid, 1'b0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (result_valid) seen = 1'b1;
    end
    checkOutput("post-reset no result_valid", seen, 1'b0);
    checkOutput("post-reset quotient", quotient, '0);

    // Back-to-back: start held across DONE launches the next division.
    @(negedge clock);
    signed_div = 1'b0;
    operand1   = 32'd100;
    operand2   = 32'd7;
    start      = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (result_valid) begin
        lat = n;
        break;
      end
    end
    checkOutput("b2b first latency", lat, 33);
    checkOutput("b2b first quotient", quotient, 32'd14);
    checkOutput("b2b first remainder", remainder, 32'd2);
    operand1 = 32'd50;
    operand2 = 32'd6;
    lat2 = -1;
    for (int m = 1; m <= 40; m++) begin
      @(negedge clock);
      if (m == 1) checkOutput("b2b stall_req in IDLE", stall_req, 1'b1);
      if (result_valid) begin
        lat2 = m;
        break;
      end
    end
    start = 1'b0;
    checkOutput("b2b second spacing", lat2, 34);
    checkOutput("b2b second quotient", quotient, 32'd8);
    checkOutput("b2b second remainder", remainder, 32'd2);

    // Annul in DONE still lets the already-latched result pulse.
    @(negedge clock);
    @(negedge clock);
    operand1 = 32'h55;
    operand2 = 32'h0;
    start    = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    annul = 1'b1;
    #1;
    checkOutput("annul DONE result_valid", result_valid, 1'b1);
    checkOutput("annul DONE remainder", remainder, 32'h55);
    checkOutput("annul DONE div_by_zero", div_by_zero, 1'b1);
    @(negedge clock);
    annul = 1'b0;
    #1;
    checkOutput("annul DONE pulse ends", result_valid, 1'b0);

    // Annul with start in IDLE: no stall and no capture.
    @(negedge clock);
    operand1 = 32'd10;
    operand2 = 32'd2;
    start    = 1'b1;
    annul    = 1'b1;
    #1;
    checkOutput("annul IDLE stall_req", stall_req, 1'b0);
    @(negedge clock);
    start = 1'b0;
    annul = 1'b0;
    #1;
    checkOutput("annul IDLE no capture", stall_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
